// File: rtl/cursor_scheduler.sv
// cursor_scheduler
// Turns debounced button levels into cursor moves on a COLS x ROWS grid,
// arbitrates simultaneous presses and issues select requests over req/ack.
// Optional macro: CURSOR_REPEAT_EN adds hold-to-repeat (tick generator,
// repeat counter, HOLD/REPEAT states). Without it every rising edge of a
// direction button produces exactly one move.
module cursor_scheduler #(
    parameter int COLS         = 8,
    parameter int ROWS         = 6,
    parameter int TICK_DIV     = 100000,
    parameter int REPEAT_DELAY = 400,
    parameter int REPEAT_RATE  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up_in,
    input  logic       right_in,
    input  logic       down_in,
    input  logic       left_in,
    input  logic       s_in,
    input  logic       busy,
    output logic [3:0] cur_x,
    output logic [3:0] cur_y,
    output logic       moved,
    output logic       sel_req,
    output logic [3:0] sel_x,
    output logic [3:0] sel_y,
    input  logic       sel_ack
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_SEL_WAIT = 2'd3
    } state_t;

    // Button bit positions double as direction codes for bits 0..3
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;
    localparam int         BTN_SEL   = 4;

    localparam logic [3:0] X_MAX = 4'(COLS - 1);
    localparam logic [3:0] Y_MAX = 4'(ROWS - 1);

    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] edge_pulse;

    state_t     state_reg, state_next;
    logic [3:0] cur_x_reg, cur_x_next;
    logic [3:0] cur_y_reg, cur_y_next;
    logic       moved_reg;
    logic       sel_req_reg, sel_req_next;
    logic [3:0] sel_x_reg, sel_x_next;
    logic [3:0] sel_y_reg, sel_y_next;

    logic       sel_edge;
    logic       dir_edge;
    logic [1:0] dir_win;
    logic       move_en;
    logic [1:0] move_dir;

    assign btn_raw = {s_in, left_in, down_in, right_in, up_in};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_btn
            logic sync1_reg, sync2_reg, hist_reg;

            // Two-flop synchronizer plus history flop for rising-edge detect
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    hist_reg  <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    hist_reg  <= sync2_reg;
                end
            end

            // While busy every edge is swallowed; the history flop still tracks
            // the level so a button held across busy needs a fresh press
            assign btn_level[gi]  = sync2_reg;
            assign edge_pulse[gi] = sync2_reg & ~hist_reg & ~busy;
        end
    endgenerate

    // Arbitration: select outranks directions, directions up > right > down > left
    always_comb begin
        sel_edge = edge_pulse[BTN_SEL];
        dir_edge = |edge_pulse[3:0];
        if (edge_pulse[DIR_UP])         dir_win = DIR_UP;
        else if (edge_pulse[DIR_RIGHT]) dir_win = DIR_RIGHT;
        else if (edge_pulse[DIR_DOWN])  dir_win = DIR_DOWN;
        else                            dir_win = DIR_LEFT;
    end

`ifdef CURSOR_REPEAT_EN
    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [REP_W-1:0]  DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0]  RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    logic [TICK_W-1:0] tick_cnt_reg;
    logic              tick;
    logic [REP_W-1:0]  rep_cnt_reg, rep_cnt_next;
    logic [1:0]        dir_reg, dir_next;

    assign tick = (tick_cnt_reg == TICK_LAST);

    // Free-running 1 ms tick divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt_reg <= '0;
        else if (tick) tick_cnt_reg <= '0;
        else           tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end

    // Repeat counter and the latched held direction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_reg <= '0;
            dir_reg     <= DIR_UP;
        end else begin
            rep_cnt_reg <= rep_cnt_next;
            dir_reg     <= dir_next;
        end
    end
`else
    // Repeat timing parameters have no meaning without hold-to-repeat
    logic [31:0] unused_repeat_cfg;
    assign unused_repeat_cfg = 32'(TICK_DIV) ^ 32'(REPEAT_DELAY) ^ 32'(REPEAT_RATE);
`endif

    // Next-state, move request and select capture
    always_comb begin
        state_next   = state_reg;
        sel_req_next = sel_req_reg;
        sel_x_next   = sel_x_reg;
        sel_y_next   = sel_y_reg;
        move_en      = 1'b0;
        move_dir     = dir_win;
`ifdef CURSOR_REPEAT_EN
        rep_cnt_next = rep_cnt_reg;
        dir_next     = dir_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (sel_edge) begin
                    sel_req_next = 1'b1;
                    sel_x_next   = cur_x_reg;
                    sel_y_next   = cur_y_reg;
                    state_next   = ST_SEL_WAIT;
                end else if (dir_edge) begin
                    move_en = 1'b1;
`ifdef CURSOR_REPEAT_EN
                    dir_next     = dir_win;
                    rep_cnt_next = '0;
                    state_next   = ST_HOLD;
`endif
                end
            end
`ifdef CURSOR_REPEAT_EN
            ST_HOLD, ST_REPEAT: begin
                if (sel_edge) begin
                    sel_req_next = 1'b1;
                    sel_x_next   = cur_x_reg;
                    sel_y_next   = cur_y_reg;
                    rep_cnt_next = '0;
                    state_next   = ST_SEL_WAIT;
                end else if (dir_edge) begin
                    move_en      = 1'b1;
                    dir_next     = dir_win;
                    rep_cnt_next = '0;
                    state_next   = ST_HOLD;
                end else if (!btn_level[dir_reg]) begin
                    rep_cnt_next = '0;
                    state_next   = ST_IDLE;
                end else if (tick) begin
                    if ((state_reg == ST_HOLD) ? (rep_cnt_reg == DELAY_LAST)
                                               : (rep_cnt_reg == RATE_LAST)) begin
                        move_en      = 1'b1;
                        move_dir     = dir_reg;
                        rep_cnt_next = '0;
                        state_next   = ST_REPEAT;
                    end else begin
                        rep_cnt_next = rep_cnt_reg + 1'b1;
                    end
                end
            end
`endif
            ST_SEL_WAIT: begin
                if (sel_ack) begin
                    sel_req_next = 1'b0;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Busy freezes repeat timing and abandons any hold, but never a select
        if (busy) begin
            move_en = 1'b0;
`ifdef CURSOR_REPEAT_EN
            rep_cnt_next = '0;
`endif
            if (state_reg != ST_SEL_WAIT) state_next = ST_IDLE;
        end
    end

    // Explicit compare-and-wrap cursor stepping
    always_comb begin
        cur_x_next = cur_x_reg;
        cur_y_next = cur_y_reg;
        if (move_en) begin
            case (move_dir)
                DIR_UP:   cur_y_next = (cur_y_reg == 4'd0)  ? Y_MAX : cur_y_reg - 4'd1;
                DIR_DOWN: cur_y_next = (cur_y_reg == Y_MAX) ? 4'd0  : cur_y_reg + 4'd1;
                DIR_LEFT: cur_x_next = (cur_x_reg == 4'd0)  ? X_MAX : cur_x_reg - 4'd1;
                default:  cur_x_next = (cur_x_reg == X_MAX) ? 4'd0  : cur_x_reg + 4'd1;
            endcase
        end
    end

    // State, cursor and select registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cur_x_reg   <= 4'd0;
            cur_y_reg   <= 4'd0;
            moved_reg   <= 1'b0;
            sel_req_reg <= 1'b0;
            sel_x_reg   <= 4'd0;
            sel_y_reg   <= 4'd0;
        end else begin
            state_reg   <= state_next;
            cur_x_reg   <= cur_x_next;
            cur_y_reg   <= cur_y_next;
            moved_reg   <= move_en;
            sel_req_reg <= sel_req_next;
            sel_x_reg   <= sel_x_next;
            sel_y_reg   <= sel_y_next;
        end
    end

    assign cur_x   = cur_x_reg;
    assign cur_y   = cur_y_reg;
    assign moved   = moved_reg;
    assign sel_req = sel_req_reg;
    assign sel_x   = sel_x_reg;
    assign sel_y   = sel_y_reg;

endmodule

// File: tb/tb_cursor_scheduler.sv
// tb_cursor_scheduler: directed vectors for cursor_scheduler (COLS=8, ROWS=6,
// TICK_DIV=10). Repeat expectations follow CURSOR_REPEAT_EN when defined.
module tb_cursor_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up_in = 1'b0, right_in = 1'b0, down_in = 1'b0, left_in = 1'b0, s_in = 1'b0;
    logic       busy = 1'b0;
    logic       sel_ack = 1'b0;
    logic [3:0] cur_x, cur_y, sel_x, sel_y;
    logic       moved, sel_req;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int move_q[$];

    cursor_scheduler #(
        .COLS(8), .ROWS(6), .TICK_DIV(10), .REPEAT_DELAY(400), .REPEAT_RATE(100)
    ) dut (
        .clk(clk), .rst(rst),
        .up_in(up_in), .right_in(right_in), .down_in(down_in), .left_in(left_in),
        .s_in(s_in), .busy(busy),
        .cur_x(cur_x), .cur_y(cur_y), .moved(moved),
        .sel_req(sel_req), .sel_x(sel_x), .sel_y(sel_y), .sel_ack(sel_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log the cycle of every moved pulse
    always @(negedge clk) if (moved === 1'b1) move_q.push_back(cyc);

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: up_in    = v;
            1: right_in = v;
            2: down_in  = v;
            3: left_in  = v;
            default: s_in = v;
        endcase
    endtask

    // Hold one button for 4 cycles, release, let the pipeline settle
    task automatic press(input int idx);
        @(posedge clk); #1 set_btn(idx, 1'b1);
        repeat (4) @(posedge clk); #1 set_btn(idx, 1'b0);
        repeat (4) @(posedge clk); #1;
        $display("press %0d -> cur=(%0d,%0d) sel_req=%0d", idx, cur_x, cur_y, sel_req);
    endtask

    task automatic press2(input int a, input int b);
        @(posedge clk); #1 set_btn(a, 1'b1); set_btn(b, 1'b1);
        repeat (4) @(posedge clk); #1 set_btn(a, 1'b0); set_btn(b, 1'b0);
        repeat (4) @(posedge clk); #1;
        $display("press %0d+%0d -> cur=(%0d,%0d) sel_req=%0d", a, b, cur_x, cur_y, sel_req);
    endtask

    task automatic ack_pulse;
        @(posedge clk); #1 sel_ack = 1'b1;
        @(posedge clk); #1 sel_ack = 1'b0;
        $display("ack -> sel_req=%0d", sel_req);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_vec++; if (cur_x !== 4'd0)   begin n_err++; $display("FAIL rst_cur_x got %0d want 0", cur_x); end
        n_vec++; if (cur_y !== 4'd0)   begin n_err++; $display("FAIL rst_cur_y got %0d want 0", cur_y); end
        n_vec++; if (moved !== 1'b0)   begin n_err++; $display("FAIL rst_moved got %0d want 0", moved); end
        n_vec++; if (sel_req !== 1'b0) begin n_err++; $display("FAIL rst_sel_req got %0d want 0", sel_req); end
        n_vec++; if (sel_x !== 4'd0)   begin n_err++; $display("FAIL rst_sel_x got %0d want 0", sel_x); end
        n_vec++; if (sel_y !== 4'd0)   begin n_err++; $display("FAIL rst_sel_y got %0d want 0", sel_y); end
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        $display("reset released -> cur=(%0d,%0d)", cur_x, cur_y);
    endtask

    // Three right presses: move lands exactly 3 edges after the input rise
    task automatic test_right_latency;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 right_in = 1'b1;
            repeat (2) @(posedge clk); #1;
            n_vec++; if (moved !== 1'b0) begin n_err++; $display("FAIL lat_early_moved[%0d] got %0d want 0", i, moved); end
            n_vec++; if (cur_x !== 4'(i)) begin n_err++; $display("FAIL lat_early_x[%0d] got %0d want %0d", i, cur_x, i); end
            @(posedge clk); #1;
            n_vec++; if (moved !== 1'b1) begin n_err++; $display("FAIL lat_moved[%0d] got %0d want 1", i, moved); end
            n_vec++; if (cur_x !== 4'(i + 1)) begin n_err++; $display("FAIL lat_x[%0d] got %0d want %0d", i, cur_x, i + 1); end
            right_in = 1'b0;
            @(posedge clk); #1;
            n_vec++; if (moved !== 1'b0) begin n_err++; $display("FAIL lat_pulse_len[%0d] got %0d want 0", i, moved); end
            repeat (4) @(posedge clk); #1;
            $display("right step %0d -> cur=(%0d,%0d)", i, cur_x, cur_y);
        end
    endtask

    // Wrap at both grid edges
    task automatic test_wrap;
        press(0);
        n_vec++; if (cur_y !== 4'd5) begin n_err++; $display("FAIL wrap_up got %0d want 5", cur_y); end
        for (int i = 0; i < 4; i++) press(1);
        n_vec++; if (cur_x !== 4'd7) begin n_err++; $display("FAIL wrap_pre_x got %0d want 7", cur_x); end
        press(1);
        n_vec++; if (cur_x !== 4'd0) begin n_err++; $display("FAIL wrap_right got %0d want 0", cur_x); end
    endtask

    // Simultaneous edges: up beats left, select beats down
    task automatic test_arbitration;
        press2(0, 3);
        n_vec++; if (cur_y !== 4'd4) begin n_err++; $display("FAIL arb_up_y got %0d want 4", cur_y); end
        n_vec++; if (cur_x !== 4'd0) begin n_err++; $display("FAIL arb_left_x got %0d want 0", cur_x); end
        press2(4, 2);
        n_vec++; if (sel_req !== 1'b1) begin n_err++; $display("FAIL arb_sel_req got %0d want 1", sel_req); end
        n_vec++; if (cur_y !== 4'd4) begin n_err++; $display("FAIL arb_down_y got %0d want 4", cur_y); end
        n_vec++; if (sel_y !== 4'd4) begin n_err++; $display("FAIL arb_sel_y got %0d want 4", sel_y); end
        ack_pulse();
        n_vec++; if (sel_req !== 1'b0) begin n_err++; $display("FAIL arb_ack got %0d want 0", sel_req); end
    endtask

    // Select handshake with moves ignored while waiting, then a 1-cycle handshake
    task automatic test_select;
        int n0;
        press(1); press(1); press(0);
        n_vec++; if ({cur_x, cur_y} !== {4'd2, 4'd3}) begin n_err++; $display("FAIL sel_pos got (%0d,%0d) want (2,3)", cur_x, cur_y); end
        press(4);
        n_vec++; if (sel_req !== 1'b1) begin n_err++; $display("FAIL sel_req got %0d want 1", sel_req); end
        n_vec++; if ({sel_x, sel_y} !== {4'd2, 4'd3}) begin n_err++; $display("FAIL sel_xy got (%0d,%0d) want (2,3)", sel_x, sel_y); end
        n0 = move_q.size();
        press(1); press(1);
        n_vec++; if (cur_x !== 4'd2) begin n_err++; $display("FAIL sel_wait_x got %0d want 2", cur_x); end
        n_vec++; if (move_q.size() !== n0) begin n_err++; $display("FAIL sel_wait_moves got %0d want %0d", move_q.size(), n0); end
        n_vec++; if (sel_req !== 1'b1) begin n_err++; $display("FAIL sel_wait_req got %0d want 1", sel_req); end
        ack_pulse();
        n_vec++; if (sel_req !== 1'b0) begin n_err++; $display("FAIL sel_ack_drop got %0d want 0", sel_req); end
        // ack held high before and during the request
        @(posedge clk); #1 sel_ack = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_vec++; if (sel_req !== 1'b0) begin n_err++; $display("FAIL ack_idle got %0d want 0", sel_req); end
        s_in = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_vec++; if (sel_req !== 1'b1) begin n_err++; $display("FAIL hs1_rise got %0d want 1", sel_req); end
        @(posedge clk); #1;
        n_vec++; if (sel_req !== 1'b0) begin n_err++; $display("FAIL hs1_drop got %0d want 0", sel_req); end
        s_in = 1'b0; sel_ack = 1'b0;
        repeat (4) @(posedge clk); #1;
        $display("one-cycle handshake -> sel_req=%0d", sel_req);
    endtask

    // Hold down for 5010 cycles from (2,3)
    task automatic test_repeat;
        int n0, base, d1;
        n0 = move_q.size();
        @(posedge clk); #1 down_in = 1'b1; base = cyc;
        repeat (5010) @(posedge clk); #1 down_in = 1'b0;
        repeat (2000) @(posedge clk); #1;
        $display("hold down -> moves=%0d cur=(%0d,%0d)", move_q.size() - n0, cur_x, cur_y);
`ifdef CURSOR_REPEAT_EN
        n_vec++; if (move_q.size() - n0 !== 3) begin n_err++; $display("FAIL rep_count got %0d want 3", move_q.size() - n0); end
        n_vec++; if (cur_y !== 4'd0) begin n_err++; $display("FAIL rep_y got %0d want 0", cur_y); end
        if (move_q.size() - n0 >= 3) begin
            n_vec++; if (move_q[n0] - base !== 3) begin n_err++; $display("FAIL rep_first got %0d want 3", move_q[n0] - base); end
            d1 = move_q[n0 + 1] - base;
            n_vec++; if (d1 < 3990 || d1 > 4005) begin n_err++; $display("FAIL rep_delay got %0d want 3990..4005", d1); end
            n_vec++; if (move_q[n0 + 2] - move_q[n0 + 1] !== 1000) begin n_err++; $display("FAIL rep_rate got %0d want 1000", move_q[n0 + 2] - move_q[n0 + 1]); end
        end
`else
        n_vec++; if (move_q.size() - n0 !== 1) begin n_err++; $display("FAIL hold_count got %0d want 1", move_q.size() - n0); end
        n_vec++; if (cur_y !== 4'd4) begin n_err++; $display("FAIL hold_y got %0d want 4", cur_y); end
        if (move_q.size() - n0 >= 1) begin
            n_vec++; if (move_q[n0] - base !== 3) begin n_err++; $display("FAIL hold_first got %0d want 3", move_q[n0] - base); end
        end
`endif
    endtask

    // Busy swallows an edge; held button needs re-press; reset during SEL_WAIT
    task automatic test_busy_and_reset;
        int n0;
        n0 = move_q.size();
        @(posedge clk); #1 busy = 1'b1;
        @(posedge clk); #1 left_in = 1'b1;
        repeat (10) @(posedge clk); #1 busy = 1'b0;
        repeat (10) @(posedge clk); #1;
        $display("busy + held left -> cur=(%0d,%0d)", cur_x, cur_y);
        n_vec++; if (cur_x !== 4'd2) begin n_err++; $display("FAIL busy_x got %0d want 2", cur_x); end
        n_vec++; if (move_q.size() !== n0) begin n_err++; $display("FAIL busy_moves got %0d want %0d", move_q.size(), n0); end
        left_in = 1'b0;
        repeat (5) @(posedge clk); #1;
        press(3);
        n_vec++; if (cur_x !== 4'd1) begin n_err++; $display("FAIL repress_x got %0d want 1", cur_x); end
        press(4);
        n_vec++; if (sel_req !== 1'b1) begin n_err++; $display("FAIL pre_rst_req got %0d want 1", sel_req); end
        @(posedge clk); #2 rst = 1'b1;
        #1;
        $display("reset in SEL_WAIT -> cur=(%0d,%0d) sel_req=%0d", cur_x, cur_y, sel_req);
        n_vec++; if (sel_req !== 1'b0) begin n_err++; $display("FAIL mid_rst_req got %0d want 0", sel_req); end
        n_vec++; if ({cur_x, cur_y} !== 8'h00) begin n_err++; $display("FAIL mid_rst_pos got (%0d,%0d) want (0,0)", cur_x, cur_y); end
        n_vec++; if ({sel_x, sel_y} !== 8'h00) begin n_err++; $display("FAIL mid_rst_sel got (%0d,%0d) want (0,0)", sel_x, sel_y); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk); #1;
        n_vec++; if (sel_req !== 1'b0) begin n_err++; $display("FAIL post_rst_req got %0d want 0", sel_req); end
    endtask

    initial begin
        test_reset();
        test_right_latency();
        test_wrap();
        test_arbitration();
        test_select();
        test_repeat();
        test_busy_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cursor_scheduler.md
Name: cursor_scheduler

Overview:
- Consumes the five debounced button levels (up/right/down/left/select) and turns them into discrete cursor moves on the COLS x ROWS tile grid.
- Arbitrates simultaneous presses, generates hold-to-repeat moves and issues select requests to the game logic over a req/ack handshake.
- Sits between the input debouncing stage and the board/match logic.
- Owns the only copy of the cursor position.

Parameters:
- COLS, 8, grid width in tiles (2..16)
- ROWS, 6, grid height in tiles (2..16)
- TICK_DIV, 100000, clk cycles per 1 ms repeat tick (100 MHz -> 1 kHz)
- REPEAT_DELAY, 400, ticks a direction must be held before the first repeat
- REPEAT_RATE, 100, ticks between subsequent repeats

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- up_in  in  1  debounced level, asynchronous to clk
- right_in  in  1  debounced level, asynchronous to clk
- down_in  in  1  debounced level, asynchronous to clk
- left_in  in  1  debounced level, asynchronous to clk
- s_in  in  1  debounced select level, asynchronous to clk
- busy  in  1  game logic busy (animation/clear); discards new input events
- cur_x  out  4  cursor column, 0..COLS-1
- cur_y  out  4  cursor row, 0..ROWS-1
- moved  out  1  one-cycle pulse on every cursor change
- sel_req  out  1  select request
- sel_x  out  4  column captured at request
- sel_y  out  4  row captured at request
- sel_ack  in  1  game logic accepts the select

Behaviour:
- Reset (async, rst=1):
  - cur_x=0, cur_y=0, moved=0, sel_req=0, sel_x=0, sel_y=0.
  - State IDLE; tick counter and repeat counter = 0; sync flops and edge-detect history = 0.
- Input path:
  - Each *_in goes through a 2-flop synchronizer, then rising-edge detect (sync=1, previous=0).
  - An input change at edge n produces the edge pulse at edge n+2.
  - The cursor register and moved update at edge n+3.
- Arbitration, evaluated per cycle on edge pulses:
  - Select beats all directions.
  - Direction priority is up > right > down > left.
  - Losing edges in the same cycle are dropped, not queued.
- Moves:
  - up: cur_y-1; at 0 wraps to ROWS-1.
  - down: cur_y+1; at ROWS-1 wraps to 0.
  - left/right: same rule on cur_x with COLS.
  - Arithmetic is unsigned 4-bit with explicit compare-and-wrap, never modulo.
  - moved pulses for exactly one cycle with each update.
- busy=1:
  - All edge pulses are discarded and the repeat counter is held at 0.
  - The state returns to IDLE unless it is SEL_WAIT.
  - A button already held when busy falls does not move until it is released and pressed again.
- States:
  - IDLE:
    - Direction edge: move, latch the direction, clear the repeat counter, go to HOLD.
    - Select edge: capture sel_x/sel_y = cur_x/cur_y, assert sel_req, go to SEL_WAIT.
  - HOLD:
    - Latched direction released: go to IDLE.
    - Higher-arbitrated new direction edge: move, relatch, restart HOLD.
    - Select edge: behaves as in IDLE.
    - Counter reaches REPEAT_DELAY ticks: move, clear the counter, go to REPEAT.
  - REPEAT:
    - Every REPEAT_RATE ticks: move.
    - Release, new edge or select: same handling as HOLD.
  - SEL_WAIT:
    - sel_req, sel_x and sel_y are held stable.
    - Direction and select edges are ignored.
    - sel_ack sampled high: sel_req drops at the next edge, go to IDLE.
    - sel_ack high in the same cycle sel_req rises is legal and completes a 1-cycle handshake.
- sel_ack while sel_req=0 is ignored.
- Tick generator:
  - Free-running 0..TICK_DIV-1 counter; the tick is a 1-cycle pulse at TICK_DIV-1.
  - The repeat counter advances only on ticks.
- Reset mid-operation: any state returns immediately to the reset values, including dropping sel_req with no ack.

Optional Feature:
- CURSOR_REPEAT_EN defined: HOLD/REPEAT states, the tick generator and the repeat counters exist, as described above.
- Undefined:
  - No tick logic; exactly one move per rising edge.
  - After a move, the FSM stays in IDLE.
  - REPEAT_DELAY and REPEAT_RATE are unused.
  - All other behaviour is unchanged, including the SEL_WAIT handshake.

Test Plan:
1. Reset, then right_in pulsed 3 times -> cur_x 0->1->2->3, three moved pulses, each 3 cycles after the input rise.
2. cur_y=0, up_in pulse -> cur_y=5. cur_x=7, right_in pulse -> cur_x=0 (wrap, COLS=8, ROWS=6).
3. up_in and left_in rise on the same edge -> only cur_y changes. s_in and down_in rise together -> sel_req=1, cur_y unchanged.
4. Cursor (2,3), s_in pulse -> sel_req=1 with sel_x=2, sel_y=3. right_in pulses while waiting are ignored (cur_x stays 2). sel_ack=1 for 1 cycle -> sel_req=0 next edge.
5. With CURSOR_REPEAT_EN and TICK_DIV=10, hold down_in for 4000+1000+10 cycles -> moves at cycles 3, ~4003, ~5003. Release -> no further moves.
6. busy=1 while left_in rises and stays high; busy drops -> no move. Release then press left_in -> one move. rst asserted mid-SEL_WAIT -> sel_req=0, cursor (0,0) immediately.
